// File: rtl/ysub_serial.sv
// Bit-serial 32-bit subtractor: z = a - b, computed LSB-first as a + ~b + 1, one bit per clock.
// Optional build macro YSUB_OVF_EN adds the signed-overflow output ovf.
module ysub_serial (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z,
  output logic        cout,
  output logic        busy,
`ifdef YSUB_OVF_EN
  output logic        ovf,
`endif
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] z_reg;
  logic        carry_reg;
  logic        cout_reg;
  logic [4:0]  cnt_reg;
  logic        accept;
  logic        last_step;
  logic        a_bit;
  logic        nb_bit;
  logic        sum_bit;
  logic        carry_next;
`ifdef YSUB_OVF_EN
  logic        ovf_reg;
`endif

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == 5'd31) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One full-adder step on the current bit of a and the inverted bit of b.
  assign a_bit      = a_reg[cnt_reg];
  assign nb_bit     = ~b_reg[cnt_reg];
  assign sum_bit    = a_bit ^ nb_bit ^ carry_reg;
  assign carry_next = (a_bit & nb_bit) | (a_bit & carry_reg) | (nb_bit & carry_reg);
  assign last_step  = (state_reg == RUN) && (cnt_reg == 5'd31);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      z_reg     <= 32'd0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= 5'd0;
`ifdef YSUB_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= 1'b1;
        cnt_reg   <= 5'd0;
      end else if (state_reg == RUN) begin
        // Sum bits enter at the MSB so bit 0 lands at z[0] after 32 shifts.
        z_reg     <= {sum_bit, z_reg[31:1]};
        carry_reg <= carry_next;
        cnt_reg   <= cnt_reg + 5'd1;
        if (last_step) begin
          cout_reg <= carry_next;
`ifdef YSUB_OVF_EN
          ovf_reg  <= (a_reg[31] != b_reg[31]) && (sum_bit != a_reg[31]);
`endif
        end
      end
    end
  end

  assign z    = z_reg;
  assign cout = cout_reg;
  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
`ifdef YSUB_OVF_EN
  assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_ysub_serial.sv
// Self-checking bench for ysub_serial: timeline model of accepted operations plus directed literal cases.
// Define YSUB_OVF_EN for both bench and RTL to exercise the ovf output.
module tb_ysub_serial;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] z;
  logic        cout;
  logic        busy;
  logic        done;
`ifdef YSUB_OVF_EN
  logic        ovf;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;

  ysub_serial dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .z     (z),
    .cout  (cout),
    .busy  (busy),
`ifdef YSUB_OVF_EN
    .ovf   (ovf),
`endif
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks when each accepted operation must complete and what it must produce.
  bit          m_active = 1'b0;
  int          m_done_cyc = -10;
  logic [31:0] m_z = 32'd0;
  logic        m_cout = 1'b0;
  logic        m_ovf = 1'b0;
  logic [31:0] p_z;
  logic        p_cout;
  logic        p_ovf;

  always @(posedge clk) begin
    longint d;
    cyc++;
    if (reset) begin
      m_active = 1'b0;
      m_z      = 32'd0;
      m_cout   = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      if (start && (!m_active || (cyc - 1 == m_done_cyc))) begin
        m_active   = 1'b1;
        m_done_cyc = cyc + 32;
        p_z        = a - b;
        p_cout     = (a >= b);
        d          = longint'($signed(a)) - longint'($signed(b));
        p_ovf      = (d > 64'sd2147483647) || (d < -64'sd2147483648);
      end else if (m_active && (cyc - 1 == m_done_cyc)) begin
        m_active = 1'b0;
      end
      if (m_active && cyc == m_done_cyc) begin
        m_z    = p_z;
        m_cout = p_cout;
        m_ovf  = p_ovf;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    bit exp_done;
    bit exp_busy;
    if (cyc > 0) begin
      exp_done = m_active && (cyc == m_done_cyc);
      exp_busy = m_active && (cyc < m_done_cyc);
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      if (!exp_busy) begin
        chk("z", z, m_z);
        chk("cout", {31'd0, cout}, {31'd0, m_cout});
`ifdef YSUB_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
`endif
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  // Presents start for one cycle from the current cycle and waits (bounded) for done.
  // lat counts cycles from the start cycle to the done cycle.
  task automatic op(input logic [31:0] ai, input logic [31:0] bi, output int lat);
    start = 1'b1;
    a     = ai;
    b     = bi;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op a=%h b=%h -> z=%h cout=%b latency=%0d", ai, bi, z, cout, lat);
  endtask

  initial begin
    int lat;
    int d0;
    int ra;
    int rb;
    logic [31:0] ua;
    logic [31:0] ub;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_z", z, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // Start in the very first cycle after reset deasserts.
    reset = 1'b0;
    op(32'd20, 32'd7, lat);
    chk("lat_20_7", lat, 33);
    chk("z_20_7", z, 32'd13);
    chk("cout_20_7", {31'd0, cout}, 32'd1);
`ifdef YSUB_OVF_EN
    chk("ovf_20_7", {31'd0, ovf}, 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("hold_z", z, 32'd13);

    op(32'd5, 32'd9, lat);
    chk("z_5_9", z, 32'hFFFF_FFFC);
    chk("cout_5_9", {31'd0, cout}, 32'd0);

`ifdef YSUB_OVF_EN
    op(32'h8000_0000, 32'd1, lat);
    chk("z_min_1", z, 32'h7FFF_FFFF);
    chk("ovf_min_1", {31'd0, ovf}, 32'd1);
    chk("cout_min_1", {31'd0, cout}, 32'd1);
`endif

    // Start pulse during RUN must be ignored.
    repeat (2) @(posedge clk);
    #1;
    d0 = done_cnt;
    start = 1'b1; a = 32'd100; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; a = 32'd0; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("z_ignore", z, 32'd99);
    repeat (40) @(posedge clk);
    #1;
    chk("one_done", done_cnt - d0, 1);
    $display("ignored start: z=%h dones=%0d", z, done_cnt - d0);

    // Reset mid-RUN abandons the operation.
    start = 1'b1; a = 32'd55; b = 32'd12;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_z", z, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    d0 = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_nodone", done_cnt - d0, 0);
    op(32'd3, 32'd3, lat);
    chk("z_3_3", z, 32'd0);
    chk("cout_3_3", {31'd0, cout}, 32'd1);

    // Back-to-back: each new start is presented in the done cycle of the previous one.
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      ra = int'($urandom_range(198)) - 99;
      rb = int'($urandom_range(198)) - 99;
      ua = ra;
      ub = rb;
      op(ua, ub, lat);
      chk("b2b_spacing", lat, 33);
      chk("b2b_z", z, ua - ub);
    end
    @(posedge clk); #1;

    // Full-range random operands, with idle gaps.
    for (int i = 0; i < 10; i++) begin
      ua = $urandom;
      ub = (i == 3) ? ua : $urandom;
      op(ua, ub, lat);
      chk("rnd_z", z, ua - ub);
      repeat ($urandom_range(3)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
